// File: rtl/hazard_unit.sv
// hazard_unit
//
// Pipeline hazard controller for the five-stage RISC-V core. It watches the
// execute-stage state and drives stall, flush and forwarding controls back
// into the fetch/decode/execute/memory/writeback pipeline registers.
//   - load-use hazards are resolved by stalling F/D and bubbling E;
//   - taken branches/jumps are resolved by flushing D and E;
//   - data-memory wait states freeze F/D/E/M and bubble W until MemAckM.
// Saturating event counters are kept for performance debug.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   Rs1D, Rs2D                  decode-stage source registers
//   Rs1E, Rs2E, RdE, ResultSrcE execute-stage registers / result select
//   PCSrcE                      taken branch or jump resolved in execute
//   RdM, RdW, RegWriteM/W       destination and write enable in M and W
//   MemReqM, MemAckM            data-memory request / completion
//   StallF/D/E/M, FlushD/E/W    pipeline register hold / bubble controls
//   ForwardAE, ForwardBE        operand select: 00 reg file, 01 W, 10 M
//   LoadStallCnt, FlushCnt,
//   MemWaitCnt                  saturating event counters (registered)
//   MemStateM                   0 = RUN, 1 = MEM_WAIT (registered, debug)
module hazard_unit #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           Rs1D,
   input  logic [4:0]           Rs2D,
   input  logic [4:0]           Rs1E,
   input  logic [4:0]           Rs2E,
   input  logic [4:0]           RdE,
   input  logic [1:0]           ResultSrcE,
   input  logic                 PCSrcE,
   input  logic [4:0]           RdM,
   input  logic [4:0]           RdW,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 MemReqM,
   input  logic                 MemAckM,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 StallE,
   output logic                 StallM,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic                 FlushW,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic [CNT_WIDTH-1:0] LoadStallCnt,
   output logic [CNT_WIDTH-1:0] FlushCnt,
   output logic [CNT_WIDTH-1:0] MemWaitCnt,
   output logic                 MemStateM
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t state, state_nxt;
   logic   mem_stall;
   logic   lw_stall;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
   endfunction

   // The memory stage always wins over writeback because it holds the younger result.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      if (RegWriteM && (RdM == rs) && (rs != 5'd0))
         return 2'b10;
      else if (RegWriteW && (RdW == rs) && (rs != 5'd0))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   // Hazard detection (combinational, same-cycle)
   assign mem_stall = MemReqM & ~MemAckM;
   assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

   // A memory wait freezes the whole front of the pipe, so a pending branch or
   // load-use in E is simply held and acted on once the access completes.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (mem_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else begin
         StallF = lw_stall;
         StallD = lw_stall;
         FlushE = lw_stall | PCSrcE;
         FlushD = PCSrcE;
      end
   end

   assign ForwardAE = fwd_sel(Rs1E);
   assign ForwardBE = fwd_sel(Rs2E);

   // Memory-wait FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= RUN;
      else
         state <= state_nxt;
   end

   // MEM_WAIT with MemReqM dropped is illegal; falling back to RUN keeps the
   // pipe from locking up.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (mem_stall) state_nxt = MEM_WAIT;
         MEM_WAIT: if (MemAckM || !MemReqM) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase
   end

   assign MemStateM = (state == MEM_WAIT);

   // Event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         LoadStallCnt <= '0;
         FlushCnt     <= '0;
         MemWaitCnt   <= '0;
      end else if (mem_stall) begin
         MemWaitCnt <= sat_inc(MemWaitCnt);
      end else begin
         if (lw_stall) LoadStallCnt <= sat_inc(LoadStallCnt);
         if (PCSrcE)   FlushCnt     <= sat_inc(FlushCnt);
      end
   end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It consumes the execute-stage state produced by the decode/execute pipeline register and drives the stall, flush and forwarding controls back into the fetch, decode, execute, memory and writeback pipeline registers. It resolves three kinds of hazard:
- load-use hazards, by stalling;
- taken branches and jumps, by flushing;
- data-memory wait states, through a req/ack FSM.

It also keeps saturating hazard event counters for performance debug.

## Interface
- CNT_WIDTH, 32, width of each event counter
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- Rs1D, Rs2D  input  5 each  source registers of the instruction in decode
- Rs1E, Rs2E, RdE  input  5 each  source and destination registers in execute
- ResultSrcE  input  2  result select in execute; 2'b01 = load
- PCSrcE  input  1  taken branch or jump resolved in execute
- RdM, RdW  input  5 each  destination registers in memory and writeback
- RegWriteM, RegWriteW  input  1 each  register write enables in memory and writeback
- MemReqM  input  1  load or store present in memory stage
- MemAckM  input  1  data memory completes the access this cycle
- StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register
- FlushD, FlushE, FlushW  output  1 each  load a bubble (all zero) into the corresponding register
- ForwardAE, ForwardBE  output  2 each  execute operand source: 00 = RD1E/RD2E, 01 = writeback result, 10 = memory ALU result
- LoadStallCnt, FlushCnt, MemWaitCnt  output  CNT_WIDTH each  event counters
- MemStateM  output  1  0 = RUN, 1 = MEM_WAIT (debug)

## Operation
- FSM states are RUN and MEM_WAIT. Reset state is RUN.
- memStall = MemReqM & !MemAckM, combinational, in either state.
- RUN -> MEM_WAIT when memStall is high.
- MEM_WAIT -> RUN on the cycle MemAckM is high.
- MEM_WAIT with MemReqM low is illegal. The FSM returns to RUN.
- lwStall = (ResultSrcE == 2'b01) & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D)).
- Priority: memStall > lwStall > PCSrcE.
- When memStall is high:
  - StallF, StallD, StallE and StallM are 1, and FlushW = 1.
  - FlushD and FlushE are 0. A pending branch or load-use hazard in E is held and resolved after release.
- Otherwise:
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - StallE = StallM = FlushW = 0.
- Forwarding, evaluated regardless of stalls:
  - ForwardAE = 10 if RegWriteM & (RdM == Rs1E) & (Rs1E != 0).
  - Otherwise ForwardAE = 01 if RegWriteW & (RdW == Rs1E) & (Rs1E != 0).
  - Otherwise ForwardAE = 00.
  - ForwardBE is computed the same way using Rs2E.
  - The memory stage has priority over writeback.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - LoadStallCnt increments in each cycle where lwStall is effective (memStall low).
  - FlushCnt increments in each cycle where PCSrcE is effective (memStall low).
  - MemWaitCnt increments in each cycle where memStall is high.

## Timing
- All stall, flush and forward outputs are combinational from inputs. There is no added latency, so they are valid in the same cycle and consumed at the next clock edge.
- Counters and MemStateM are registered and update one clock after the qualifying cycle.
- Reset values: MemStateM = 0 and all counters = 0. With all inputs low, every stall and flush output is 0 and both forward selects are 00.
- rst asserted at any time, including mid MEM_WAIT: FSM goes to RUN and counters clear immediately, without waiting for clk.
- MemReqM and MemAckM high in the same cycle: zero wait, no stall, FSM stays in RUN.
- An N-cycle memory wait produces exactly N stall cycles and MemWaitCnt += N.
- lwStall lasts exactly one cycle. On the next cycle the load has moved to M, so forwarding from writeback resolves the hazard.
- Load-use and taken branch in the same cycle: FlushE = 1 and FlushD = 1, StallF = StallD = 1. Both counters increment.

## Test plan
- Load x5 in E, decode reads x5 as Rs1D → one cycle with StallF = StallD = FlushE = 1; LoadStallCnt goes 0 → 1. Same case with RdE = 0 → no stall.
- PCSrcE pulsed for 1 cycle → FlushD = FlushE = 1 for that cycle only; FlushCnt = 1.
- RdM = RdW = Rs1E = 7 with RegWriteM = RegWriteW = 1 → ForwardAE = 10. Drop RegWriteM → 01. Set Rs1E = 0 → 00. Repeat the same checks on ForwardBE.
- MemReqM high, MemAckM low for 3 cycles then high → 3 cycles of StallF/D/E/M = FlushW = 1; MemStateM = 1 after the first edge, back to 0 after the ack; MemWaitCnt = 3.
- Mem wait overlapping PCSrcE = 1 → FlushD/FlushE stay 0 during the wait and assert on the ack cycle; FlushCnt increments once.
- Assert rst asynchronously mid MEM_WAIT with counters nonzero → MemStateM = 0 and all counters = 0 before the next clk edge. Separately, force a counter to saturation → it holds at all ones.
